// File: rtl/ibex_cust_bitcount.sv
// Iterative bit-count unit for the EX stage: popcount, Hamming distance and signed popcount difference,
// consuming BitsPerCycle operand bits per cycle. Define IBEX_CUST_BITCOUNT_EARLY_EXIT_EN for zero-detect early finish.
module ibex_cust_bitcount #(
  parameter int unsigned BitsPerCycle = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        kill_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [31:0] result_o
);

  localparam int unsigned NumIter  = 32 / BitsPerCycle;
  localparam logic [5:0]  LastIter = 6'(NumIter - 1);

  if (!(BitsPerCycle == 1 || BitsPerCycle == 2 || BitsPerCycle == 4 ||
        BitsPerCycle == 8 || BitsPerCycle == 16 || BitsPerCycle == 32)) begin : g_bad_bits_per_cycle
    $fatal(1, "ibex_cust_bitcount: BitsPerCycle must be 1, 2, 4, 8, 16 or 32");
  end

  typedef enum logic [1:0] {
    StIdle,
    StIter,
    StFinish
  } state_e;

  typedef enum logic [1:0] {
    OpPopc = 2'b00,
    OpHam  = 2'b01,
    OpDiff = 2'b10,
    OpRsvd = 2'b11
  } op_e;

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [31:0] sa_q, sa_d;
  logic [31:0] sb_q, sb_d;
  logic [5:0]  cnt_a_q, cnt_a_d;
  logic [5:0]  cnt_b_q, cnt_b_d;
  logic [5:0]  iter_q, iter_d;
  logic [31:0] result_q, result_d;

  logic [5:0]  cnt_a_sum, cnt_b_sum;
  logic [31:0] sa_shift, sb_shift;
  logic [6:0]  diff;
  logic        last_iter;

  function automatic logic [5:0] popc_slice(input logic [BitsPerCycle-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < BitsPerCycle; i++) begin
      c = c + 6'(v[i]);
    end
    return c;
  endfunction

  // Counters hold at most 32, so the 6-bit sums and the 7-bit difference cannot wrap.
  assign cnt_a_sum = cnt_a_q + popc_slice(sa_q[BitsPerCycle-1:0]);
  assign cnt_b_sum = cnt_b_q + popc_slice(sb_q[BitsPerCycle-1:0]);
  assign sa_shift  = sa_q >> BitsPerCycle;
  assign sb_shift  = sb_q >> BitsPerCycle;
  assign diff      = {1'b0, cnt_a_sum} - {1'b0, cnt_b_sum};

`ifdef IBEX_CUST_BITCOUNT_EARLY_EXIT_EN
  assign last_iter = (iter_q == LastIter) || ((sa_shift == '0) && (sb_shift == '0));
`else
  assign last_iter = (iter_q == LastIter);
`endif

  always_comb begin
    // NOTE: every next-state signal takes its current value first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    cnt_a_d  = cnt_a_q;
    cnt_b_d  = cnt_b_q;
    iter_d   = iter_q;
    result_d = result_q;

    unique case (state_q)
      StIdle: begin
        if (en_i) begin
          state_d = StIter;
          op_d    = op_e'(op_i);
          cnt_a_d = '0;
          cnt_b_d = '0;
          iter_d  = '0;
          unique case (op_e'(op_i))
            OpPopc: begin sa_d = operand_a_i;               sb_d = '0;          end
            OpHam:  begin sa_d = operand_a_i ^ operand_b_i; sb_d = '0;          end
            OpDiff: begin sa_d = operand_a_i;               sb_d = operand_b_i; end
            OpRsvd: begin sa_d = '0;                        sb_d = '0;          end
          endcase
        end
      end
      StIter: begin
        cnt_a_d = cnt_a_sum;
        cnt_b_d = cnt_b_sum;
        sa_d    = sa_shift;
        sb_d    = sb_shift;
        iter_d  = iter_q + 6'd1;
        if (last_iter) begin
          state_d = StFinish;
          unique case (op_q)
            OpPopc, OpHam: result_d = {26'd0, cnt_a_sum};
            OpDiff:        result_d = {{25{diff[6]}}, diff};
            OpRsvd:        result_d = '0;
          endcase
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // A flush overrides everything, including a result write on the last iteration.
    if (kill_i) begin
      state_d  = StIdle;
      cnt_a_d  = '0;
      cnt_b_d  = '0;
      iter_d   = '0;
      result_d = result_q;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      op_q     <= OpPopc;
      sa_q     <= '0;
      sb_q     <= '0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      iter_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
      iter_q   <= iter_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q != StIdle);
  assign valid_o  = (state_q == StFinish) && !kill_i;
  assign result_o = result_q;

endmodule

// File: tb/tb_ibex_cust_bitcount.sv
// Directed bench for ibex_cust_bitcount: scoreboarded results, latency, kill and reset behaviour.
module tb_ibex_cust_bitcount;

  localparam int Bpc     = 8;
  localparam int NumIter = 32 / Bpc;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        en_i;
  logic        kill_i;
  logic [1:0]  op_i;
  logic [31:0] operand_a_i;
  logic [31:0] operand_b_i;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  ibex_cust_bitcount #(.BitsPerCycle(Bpc)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .en_i        (en_i),
    .kill_i      (kill_i),
    .op_i        (op_i),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .busy_o      (busy_o),
    .valid_o     (valid_o),
    .result_o    (result_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int d;
    case (op)
      2'b00:   return 32'($countones(a));
      2'b01:   return 32'($countones(a ^ b));
      2'b10:   begin d = $countones(a) - $countones(b); return 32'(d); end
      default: return 32'd0;
    endcase
  endfunction

  // Cycle (counted from the en_i sample) at which valid_o is expected.
  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int iters;
    logic [31:0] v;
    case (op)
      2'b00:   v = a;
      2'b01:   v = a ^ b;
      2'b10:   v = a | b;
      default: v = '0;
    endcase
`ifdef IBEX_CUST_BITCOUNT_EARLY_EXIT_EN
    iters = 1;
    for (int i = 1; i < NumIter; i++) begin
      if ((v >> (i * Bpc)) != 0) iters = i + 1;
    end
`else
    iters = NumIter;
    if (v == 32'hdead_beef) iters = NumIter;
`endif
    return iters + 1;
  endfunction

  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit scramble);
    int lat;
    int cyc;
    bit done;
    logic [31:0] exp_r;
    lat = exp_lat(op, a, b);
    @(negedge clk);
    op_i = op; operand_a_i = a; operand_b_i = b; en_i = 1'b1;
    exp_q.push_back(model(op, a, b));
    done = 1'b0;
    for (cyc = 1; cyc <= 64 && !done; cyc++) begin
      @(negedge clk);
      if (scramble && cyc == 1) begin
        operand_a_i = '0; operand_b_i = '1; op_i = 2'b11;
      end
      if (valid_o) begin
        done = 1'b1;
        en_i = 1'b0;
        check({tag, "_latency"}, 32'(cyc), 32'(lat));
        check({tag, "_sb_depth"}, 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) begin
          exp_r = exp_q.pop_front();
          check({tag, "_result"}, result_o, exp_r);
        end
      end else begin
        check({tag, "_busy"}, 32'(busy_o), 32'd1);
      end
    end
    if (!done) begin
      en_i = 1'b0;
      check({tag, "_timeout"}, 32'(done), 32'd1);
      exp_q.delete();
    end
    @(negedge clk);
    check({tag, "_idle_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_idle_valid"}, 32'(valid_o), 32'd0);
  endtask

  initial begin
    int lat;
    rst_ni = 1'b0; en_i = 1'b0; kill_i = 1'b0; op_i = 2'b00;
    operand_a_i = '0; operand_b_i = '0;
    #1;
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_valid", 32'(valid_o), 32'd0);
    check("reset_result", result_o, 32'd0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;

    do_op("popc_ones", 2'b00, 32'hFFFF_FFFF, 32'h0, 1'b0);
    do_op("ham_scramble", 2'b01, 32'hF0F0_F0F0, 32'h0F0F_F0F0, 1'b1);
    do_op("diff_neg7", 2'b10, 32'h0000_0001, 32'h0000_00FF, 1'b0);
    do_op("rsvd", 2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    do_op("diff_pos32", 2'b10, 32'hFFFF_FFFF, 32'h0, 1'b0);
    do_op("diff_neg32", 2'b10, 32'h0, 32'hFFFF_FFFF, 1'b0);

    // Kill in the middle of an operation.
    @(negedge clk);
    op_i = 2'b00; operand_a_i = 32'hFFFF_FFFF; en_i = 1'b1;
    @(negedge clk);
    check("kill_busy_c1", 32'(busy_o), 32'd1);
    @(negedge clk);
    kill_i = 1'b1; en_i = 1'b0;
    #1 check("kill_valid_c2", 32'(valid_o), 32'd0);
    @(negedge clk);
    kill_i = 1'b0;
    check("kill_busy_c3", 32'(busy_o), 32'd0);
    check("kill_result_held", result_o, 32'hFFFF_FFE0);
    repeat (6) begin
      @(negedge clk);
      check("kill_no_valid", 32'(valid_o), 32'd0);
    end
    do_op("popc_after_kill", 2'b00, 32'h0000_000F, 32'h0, 1'b0);

    // Kill during the FINISH cycle.
    lat = exp_lat(2'b00, 32'hFFFF_FFFF, 32'h0);
    @(negedge clk);
    op_i = 2'b00; operand_a_i = 32'hFFFF_FFFF; en_i = 1'b1;
    repeat (lat) @(negedge clk);
    kill_i = 1'b1; en_i = 1'b0;
    #1;
    check("kfin_valid", 32'(valid_o), 32'd0);
    check("kfin_result", result_o, 32'd32);
    @(negedge clk);
    kill_i = 1'b0;
    check("kfin_busy", 32'(busy_o), 32'd0);
    check("kfin_valid_after", 32'(valid_o), 32'd0);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    op_i = 2'b00; operand_a_i = 32'hFFFF_FFFF; en_i = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_ni = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_valid", 32'(valid_o), 32'd0);
    check("mid_rst_result", result_o, 32'd0);
    en_i = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    do_op("popc_after_rst", 2'b00, 32'h8000_0001, 32'h0, 1'b0);
    do_op("popc_low2", 2'b00, 32'h0000_0003, 32'h0, 1'b0);
    do_op("ham_mixed", 2'b01, 32'hA5A5_0000, 32'h5A5A_0001, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
